imm_gen_stage: RTL

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_decode.sv | 46 ++++
 rtl/imm_gen_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format codes and defaults for the immediate generation stage.
// Codes 10-15 are illegal and decode to zero with an error flag.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] IMM_I      = 4'd0;
  localparam logic [3:0] IMM_SHAMT5 = 4'd1;
  localparam logic [3:0] IMM_S      = 4'd2;
  localparam logic [3:0] IMM_B      = 4'd3;
  localparam logic [3:0] IMM_LUI    = 4'd4;
  localparam logic [3:0] IMM_AUIPC  = 4'd5;
  localparam logic [3:0] IMM_J      = 4'd6;
  localparam logic [3:0] IMM_I2     = 4'd7;
  localparam logic [3:0] IMM_SHAMT6 = 4'd8;
  localparam logic [3:0] IMM_ZIMM   = 4'd9;

  function automatic logic is_legal_sel(input logic [3:0] sel);
    return (sel <= IMM_ZIMM);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: builds a 32-bit value, then widens
// it to XLEN by copying bit 31 (zero-extended formats have bit 31 clear).
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     inst_31_7,
  input  logic [3:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            sel_err
);

  logic [31:7] inst;
  logic [31:0] imm32;

  assign inst = inst_31_7;

  always_comb begin
    imm32   = '0;
    sel_err = 1'b0;
    case (imm_sel)
      IMM_I, IMM_I2:       imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_SHAMT5:          imm32 = {27'b0, inst[24:20]};
      IMM_S:               imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:               imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                    inst[11:8], 1'b0};
      IMM_LUI, IMM_AUIPC:  imm32 = {inst[31:12], 12'b0};
      IMM_J:               imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                    inst[30:21], 1'b0};
      IMM_SHAMT6:          imm32 = {26'b0, inst[25:20]};
      IMM_ZIMM:            imm32 = {27'b0, inst[19:15]};
      default: begin
        imm32   = '0;
        sel_err = !is_legal_sel(imm_sel);
      end
    endcase
  end

  if (XLEN == 64) begin : g_xlen64
    assign imm = {{32{imm32[31]}}, imm32};
  end else begin : g_xlen32
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes on enqueue and buffers {imm, tag, err}
// in a 2-entry skid FIFO so upstream ready never depends on downstream ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inst_31_7,
  input  logic [3:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             sel_err
);

  localparam int DEPTH = 2;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             err_mem [DEPTH];

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst_31_7(inst_31_7),
    .imm_sel  (imm_sel),
    .imm      (dec_imm),
    .sel_err  (dec_err)
  );

  // Ready comes only from the registered count, and is held low during reset.
  assign in_ready  = rst_n && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: every read is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      imm_mem[wr_ptr] <= dec_imm;
      tag_mem[wr_ptr] <= in_tag;
      err_mem[wr_ptr] <= dec_err;
    end
  end

  assign imm     = out_valid ? imm_mem[rd_ptr] : '0;
  assign out_tag = out_valid ? tag_mem[rd_ptr] : '0;
  assign sel_err = out_valid ? err_mem[rd_ptr] : 1'b0;

endmodule
